cfg_uart_mstr: RTL and testbench
================================

// Module: cfg_uart_mstr
// PURPOSE
// Bench-side configuration master for the cbc_dig config UART. Serialises a 24-bit
// command as three 8N1 bytes on TX_C, then deserialises the 16-bit, two-byte reply
// from RX_C and presents it on resp with a rsp_rdy flag. It transports bytes only and
// does not interpret command or response codes.
// PARAMETERS
// BAUD_DIV  16'd32  clk cycles per UART bit, valid range >= 4; TX and RX share it
// PORTS
// clk       in   1   clock, rising-edge
// rst_n     in   1   asynchronous active-low reset
// cmd_data  in   24  command word, captured on snd_frm
// snd_frm   in   1   one-cycle request to send cmd_data
// RX_C      in   1   serial input from the DUT's config TX; idles high
// TX_C      out  1   serial output to the DUT's config RX; idles high
// resp      out  16  last complete response, {first byte, second byte}
// rsp_rdy   out  1   high once both response bytes are received
// BEHAVIOUR
// Reset: TX_C=1, resp=16'h0000, rsp_rdy=0, TX FSM IDLE, RX FSM IDLE, byte counters 0.
// Transmit FSM: IDLE -> START -> DATA -> STOP.
// - IDLE: when snd_frm=1, latch cmd_data into a 24-bit shadow register, set byte index=0,
//   go to START. When snd_frm=1 and the FSM is not IDLE, the request is ignored
//   (no re-latch, no restart).
// - START: drive TX_C=0 for BAUD_DIV cycles.
// - DATA: 8 bits, LSB first, each held BAUD_DIV cycles.
// - STOP: drive TX_C=1 for BAUD_DIV cycles. If byte index<2, increment the index and go
//   to START with no idle gap. Otherwise return to IDLE.
// - Byte order: cmd_data[23:16], then [15:8], then [7:0].
// - The first start bit begins on the cycle after snd_frm. One frame = 30*BAUD_DIV cycles.
// Receive path:
// - RX_C is synchronised through 2 flops, and all RX logic uses the synchronised value.
// - RX FSM: IDLE -> START -> DATA -> STOP.
// - IDLE: a synchronised low level starts reception.
// - START: at BAUD_DIV/2 re-check for low. If high, treat as a glitch and return to IDLE.
// - DATA: sample each bit at bit centre, BAUD_DIV after the previous sample; LSB first.
// - STOP: sample at centre. If high, the byte is accepted. If low, it is a framing
//   error: the byte is discarded and the byte counter is unchanged.
// - Return to IDLE after the stop-bit sample, so back-to-back bytes are caught.
// Response assembly:
// - First accepted byte goes to resp_hi, second to resp_lo.
// - On the second byte: resp <= {resp_hi, byte} and rsp_rdy <= 1 in the same cycle.
//   The byte counter wraps to 0.
// - rsp_rdy stays high and resp holds until the next accepted snd_frm. That snd_frm clears
//   rsp_rdy and the RX byte counter on the next edge. resp keeps its old value until the
//   new pair is complete.
// - Bytes arriving while TX is busy are still received; the bench aligns the reply.
// - Extra bytes after a completed pair start a new pair. resp and rsp_rdy update only
//   when that pair completes.
// Mid-operation reset: asynchronously forces all reset values. A partly sent byte is
//   abandoned and TX_C returns high immediately.
// No response timeout. With no reply, rsp_rdy stays 0 indefinitely.
// TESTING
// Setup for all scenarios: BAUD_DIV=8; a behavioural UART slave on TX_C/RX_C.
// 1. Reset:
//    - Stimulus: hold rst_n=0 for 2 cycles.
//    - Required: TX_C=1, resp=0000, rsp_rdy=0, and all three stay so with no snd_frm.
// 2. Send frame:
//    - Stimulus: snd_frm with cmd_data=24'h05_1234.
//    - Required: the slave decodes bytes 05, 12, 34 in order, the frame takes 240 cycles,
//      and TX_C=1 afterwards.
// 3. Response:
//    - Stimulus: the slave replies 0x0A then 0x5A after the frame.
//    - Required: rsp_rdy rises exactly once and resp=0A5A, held until the next snd_frm.
// 4. Busy ignore:
//    - Stimulus: a second snd_frm with 24'hFFFFFF 50 cycles into scenario 2.
//    - Required: the transmitted bytes are still 05 12 34, and no second frame follows.
// 5. Back-to-back:
//    - Stimulus: 10 commands in sequence; the slave echoes each cmd_data[15:0].
//    - Required: each rsp_rdy rising edge shows the matching echo, e.g. 24'h3_2ABC -> 2ABC.
// 6. Framing error:
//    - Stimulus: the slave sends a byte with stop bit=0, then 35 and A6.
//    - Required: the bad byte is dropped and resp=35A6.

Source files
------------

// File: rtl/cfg_uart_mstr.sv
// Config UART master: sends a 24-bit command as three 8N1 bytes on TX_C and
// assembles a two-byte reply from RX_C into resp, flagged by rsp_rdy.
//
// Ports:
//   clk, rst_n    rising-edge clock, async active-low reset
//   cmd_data[23:0] command word, latched on an accepted snd_frm
//   snd_frm        one-cycle send request, ignored while TX is busy
//   RX_C           serial reply input, idles high
//   TX_C           serial command output, idles high
//   resp[15:0]     last complete reply {first byte, second byte}
//   rsp_rdy        high once a reply pair is complete
module cfg_uart_mstr #(
  parameter logic [15:0] BAUD_DIV = 16'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] cmd_data,
  input  logic        snd_frm,
  input  logic        RX_C,
  output logic        TX_C,
  output logic [15:0] resp,
  output logic        rsp_rdy
);

  localparam logic [15:0] LAST  = BAUD_DIV - 16'd1;
  localparam logic [15:0] HLAST = (BAUD_DIV >> 1) - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_t;

  // ---------------- transmit ----------------
  st_t         r_tx_st, w_tx_st;
  logic [15:0] r_tx_cnt, w_tx_cnt;
  logic [2:0]  r_tx_bit, w_tx_bit;
  logic [1:0]  r_tx_idx, w_tx_idx;
  logic [23:0] r_tx_sh;
  logic [7:0]  w_tx_byte;
  logic        w_tx_end;
  logic        w_tx_acc;
  logic        w_tx_line;

  assign w_tx_end = (r_tx_cnt == LAST);
  assign w_tx_acc = (r_tx_st == S_IDLE) && snd_frm;
  assign TX_C     = w_tx_line;

  always_comb begin
    unique case (r_tx_idx)
      2'd0:    w_tx_byte = r_tx_sh[23:16];
      2'd1:    w_tx_byte = r_tx_sh[15:8];
      default: w_tx_byte = r_tx_sh[7:0];
    endcase
  end

  always_comb begin
    w_tx_st   = r_tx_st;
    w_tx_cnt  = w_tx_end ? 16'd0 : r_tx_cnt + 16'd1;
    w_tx_bit  = r_tx_bit;
    w_tx_idx  = r_tx_idx;
    w_tx_line = 1'b1;
    unique case (r_tx_st)
      S_IDLE: begin
        w_tx_cnt = 16'd0;
        if (snd_frm) begin
          w_tx_st  = S_START;
          w_tx_idx = 2'd0;
        end
      end
      S_START: begin
        w_tx_line = 1'b0;
        if (w_tx_end) begin
          w_tx_st  = S_DATA;
          w_tx_bit = 3'd0;
        end
      end
      S_DATA: begin
        w_tx_line = w_tx_byte[r_tx_bit];
        if (w_tx_end) begin
          if (r_tx_bit == 3'd7) w_tx_st = S_STOP;
          else w_tx_bit = r_tx_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (w_tx_end) begin
          if (r_tx_idx < 2'd2) begin
            w_tx_idx = r_tx_idx + 2'd1;
            w_tx_st  = S_START;
          end else begin
            w_tx_st = S_IDLE;
          end
        end
      end
      default: w_tx_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= 16'd0;
      r_tx_bit <= 3'd0;
      r_tx_idx <= 2'd0;
      r_tx_sh  <= 24'd0;
    end else begin
      r_tx_st  <= w_tx_st;
      r_tx_cnt <= w_tx_cnt;
      r_tx_bit <= w_tx_bit;
      r_tx_idx <= w_tx_idx;
      if (w_tx_acc) r_tx_sh <= cmd_data;
    end
  end

  // ---------------- receive ----------------
  logic        r_rx_s1, r_rx_s2;
  logic        w_rx;
  st_t         r_rx_st, w_rx_st;
  logic [15:0] r_rx_cnt, w_rx_cnt;
  logic [2:0]  r_rx_bit, w_rx_bit;
  logic [7:0]  r_rx_sh, w_rx_sh;
  logic        w_rx_ok;
  logic        r_rx_bcnt;
  logic [7:0]  r_resp_hi;

  assign w_rx = r_rx_s2;

  always_comb begin
    w_rx_st  = r_rx_st;
    w_rx_cnt = r_rx_cnt + 16'd1;
    w_rx_bit = r_rx_bit;
    w_rx_sh  = r_rx_sh;
    w_rx_ok  = 1'b0;
    unique case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt = 16'd0;
        if (!w_rx) w_rx_st = S_START;
      end
      S_START: begin
        // Mid start bit: a high line here was only a glitch.
        if (r_rx_cnt == HLAST) begin
          w_rx_cnt = 16'd0;
          w_rx_bit = 3'd0;
          w_rx_st  = w_rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == LAST) begin
          w_rx_cnt = 16'd0;
          w_rx_sh  = {w_rx, r_rx_sh[7:1]};
          if (r_rx_bit == 3'd7) w_rx_st = S_STOP;
          else w_rx_bit = r_rx_bit + 3'd1;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == LAST) begin
          w_rx_cnt = 16'd0;
          w_rx_st  = S_IDLE;
          w_rx_ok  = w_rx;
        end
      end
      default: w_rx_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= 16'd0;
      r_rx_bit <= 3'd0;
      r_rx_sh  <= 8'd0;
    end else begin
      r_rx_s1  <= RX_C;
      r_rx_s2  <= r_rx_s1;
      r_rx_st  <= w_rx_st;
      r_rx_cnt <= w_rx_cnt;
      r_rx_bit <= w_rx_bit;
      r_rx_sh  <= w_rx_sh;
    end
  end

  // ---------------- reply assembly ----------------
  // A new command restarts pairing; it takes priority over a byte
  // landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_bcnt <= 1'b0;
      r_resp_hi <= 8'd0;
      resp      <= 16'h0000;
      rsp_rdy   <= 1'b0;
    end else if (w_tx_acc) begin
      r_rx_bcnt <= 1'b0;
      rsp_rdy   <= 1'b0;
    end else if (w_rx_ok) begin
      if (!r_rx_bcnt) begin
        r_resp_hi <= r_rx_sh;
        r_rx_bcnt <= 1'b1;
      end else begin
        resp      <= {r_resp_hi, r_rx_sh};
        rsp_rdy   <= 1'b1;
        r_rx_bcnt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cfg_uart_mstr.sv
// Bench for cfg_uart_mstr: UART slave model on TX_C/RX_C with scoreboard
// queues for transmitted bytes and assembled replies.
module tb_cfg_uart_mstr;

  localparam int BD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] cmd_data = 24'd0;
  logic        snd_frm = 1'b0;
  logic        RX_C = 1'b1;
  logic        TX_C;
  logic [15:0] resp;
  logic        rsp_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rsp[$];
  bit          tx_mon_en = 1'b1;

  cfg_uart_mstr #(.BAUD_DIV(16'd8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_data (cmd_data),
    .snd_frm  (snd_frm),
    .RX_C     (RX_C),
    .TX_C     (TX_C),
    .resp     (resp),
    .rsp_rdy  (rsp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference line level t cycles after the first start bit of a frame.
  function automatic logic tx_model(input logic [23:0] c, input int t);
    logic [7:0] b;
    int k;
    if (t >= 30 * BD) return 1'b1;
    case (t / (10 * BD))
      0:       b = c[23:16];
      1:       b = c[15:8];
      default: b = c[7:0];
    endcase
    k = (t % (10 * BD)) / BD;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic push_cmd(input logic [23:0] c);
    exp_tx.push_back(c[23:16]);
    exp_tx.push_back(c[15:8]);
    exp_tx.push_back(c[7:0]);
  endtask

  task automatic uart_tx(input logic [7:0] b, input logic stp);
    RX_C = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX_C = b[i];
      repeat (BD) @(negedge clk);
    end
    RX_C = stp;
    repeat (BD) @(negedge clk);
    RX_C = 1'b1;
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 80 && rsp_rdy !== 1'b1; k++) @(negedge clk);
    chk("rsp_wait", {31'd0, rsp_rdy}, 32'd1);
  endtask

  task automatic send(input logic [23:0] c);
    @(negedge clk);
    cmd_data = c;
    snd_frm  = 1'b1;
    @(negedge clk);
    snd_frm  = 1'b0;
  endtask

  // Slave receiver on TX_C.
  initial begin
    logic [7:0] b;
    logic       stp;
    forever begin
      do @(negedge clk); while (TX_C !== 1'b0);
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = TX_C;
      end
      repeat (BD) @(negedge clk);
      stp = TX_C;
      if (tx_mon_en && rst_n) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected actual=%h required=none", b);
        end else begin
          chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
          chk("tx_stop", {31'd0, stp}, 32'd1);
        end
      end
    end
  end

  // Reply monitor: one expected pair per rsp_rdy rising edge.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_rdy === 1'b1 && prev !== 1'b1) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected actual=%h required=none", resp);
        end else begin
          chk("rsp_pair", {16'd0, resp}, {16'd0, exp_rsp.pop_front()});
        end
      end
      prev = rsp_rdy;
    end
  end

  initial begin
    logic        txv[400];
    int          errs;
    logic [23:0] c;
    logic [15:0] last_rsp;
    int          gap;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, TX_C}, 32'd1);
    chk("rst_resp", {16'd0, resp}, 32'd0);
    chk("rst_rdy", {31'd0, rsp_rdy}, 32'd0);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (TX_C !== 1'b1 || resp !== 16'h0 || rsp_rdy !== 1'b0) errs++;
    end
    chk("rst_hold", errs, 0);

    // Frame with a busy-time request that must be ignored
    push_cmd(24'h051234);
    send(24'h051234);
    txv[0] = TX_C;
    for (int t = 1; t < 400; t++) begin
      @(negedge clk);
      txv[t] = TX_C;
      if (t == 50) begin
        cmd_data = 24'hFFFFFF;
        snd_frm  = 1'b1;
      end
      if (t == 51) snd_frm = 1'b0;
    end
    errs = 0;
    for (int t = 0; t < 400; t++)
      if (txv[t] !== tx_model(24'h051234, t)) errs++;
    chk("tx_wave", errs, 0);
    chk("tx_start0", {31'd0, txv[0]}, 32'd0);
    chk("tx_start1", {31'd0, txv[80]}, 32'd0);
    chk("tx_start2", {31'd0, txv[160]}, 32'd0);
    chk("tx_last_stop", {31'd0, txv[239]}, 32'd1);
    errs = 0;
    for (int t = 240; t < 400; t++) if (txv[t] !== 1'b1) errs++;
    chk("tx_no_second", errs, 0);

    // Reply 0A 5A
    exp_rsp.push_back(16'h0A5A);
    uart_tx(8'h0A, 1'b1);
    uart_tx(8'h5A, 1'b1);
    wait_rsp();
    repeat (100) @(negedge clk);
    chk("rsp_hold_rdy", {31'd0, rsp_rdy}, 32'd1);
    chk("rsp_hold_val", {16'd0, resp}, 32'h0A5A);
    last_rsp = 16'h0A5A;

    // Back-to-back echoed commands
    for (int n = 0; n < 10; n++) begin
      c = 24'($urandom);
      push_cmd(c);
      send(c);
      chk("rdy_clear", {31'd0, rsp_rdy}, 32'd0);
      chk("resp_keep", {16'd0, resp}, {16'd0, last_rsp});
      gap = $urandom_range(200, 280);
      repeat (gap) @(negedge clk);
      exp_rsp.push_back(c[15:0]);
      uart_tx(c[15:8], 1'b1);
      uart_tx(c[7:0], 1'b1);
      wait_rsp();
      last_rsp = c[15:0];
      repeat (10) @(negedge clk);
    end

    // Framing error
    push_cmd(24'h0A0B0C);
    send(24'h0A0B0C);
    repeat (260) @(negedge clk);
    uart_tx(8'h77, 1'b0);
    repeat (2 * BD) @(negedge clk);
    exp_rsp.push_back(16'h35A6);
    uart_tx(8'h35, 1'b1);
    uart_tx(8'hA6, 1'b1);
    wait_rsp();
    chk("ferr_resp", {16'd0, resp}, 32'h35A6);
    repeat (20) @(negedge clk);

    // Reset in the middle of a byte
    tx_mon_en = 1'b0;
    send(24'hA5A5A5);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx", {31'd0, TX_C}, 32'd1);
    chk("mrst_resp", {16'd0, resp}, 32'd0);
    chk("mrst_rdy", {31'd0, rsp_rdy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mrst_idle", {31'd0, TX_C}, 32'd1);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("rsp_queue_empty", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
